// File: rtl/serial_tx.sv
// rtl/serial_tx.sv - LSB-first serial transmitter with start/stop framing
// Optional even parity bit enabled by defining SERIAL_TX_PARITY_EN.
module serial_tx #(
    parameter int DATA_W    = 8,
    parameter int CLK_DIV   = 4,
    parameter int STOP_BITS = 1
) (
    input  logic              aclk,
    input  logic              srst,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    output logic              txd,
    output logic              busy
);

    localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [TW-1:0] T_LAST = TW'(CLK_DIV - 1);
    localparam logic [BW-1:0] D_LAST = BW'(DATA_W - 1);
    localparam logic [BW-1:0] S_LAST = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef SERIAL_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_shift;
    logic [TW-1:0]     r_timer;
    logic [BW-1:0]     r_idx;
    logic              r_txd;
    logic              r_ready;
    logic              r_busy;
`ifdef SERIAL_TX_PARITY_EN
    logic              r_parity;
`endif

    logic              w_bit_end;
    logic [DATA_W-1:0] w_shift_next;

    assign w_bit_end    = (r_timer == T_LAST);
    assign w_shift_next = r_shift >> 1;

    assign tx_ready = r_ready;
    assign txd      = r_txd;
    assign busy     = r_busy;

    // r_idx counts data bits in DATA and stop bits in STOP; it is zero on entry to both.
    always_ff @(posedge aclk) begin
        if (srst) begin
            r_state  <= S_IDLE;
            r_shift  <= '0;
            r_timer  <= '0;
            r_idx    <= '0;
            r_txd    <= 1'b1;
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_txd   <= 1'b1;
                    if (r_ready && tx_valid) begin
                        r_shift  <= tx_data;
                        r_state  <= S_START;
                        r_txd    <= 1'b0;
                        r_busy   <= 1'b1;
                        r_ready  <= 1'b0;
                        r_timer  <= '0;
                        r_idx    <= '0;
`ifdef SERIAL_TX_PARITY_EN
                        r_parity <= ^tx_data;
`endif
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_timer <= '0;
                        r_state <= S_DATA;
                        r_txd   <= r_shift[0];
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_timer <= '0;
                        r_shift <= w_shift_next;
                        if (r_idx == D_LAST) begin
                            r_idx <= '0;
`ifdef SERIAL_TX_PARITY_EN
                            r_state <= S_PARITY;
                            r_txd   <= r_parity;
`else
                            r_state <= S_STOP;
                            r_txd   <= 1'b1;
`endif
                        end else begin
                            r_idx <= r_idx + BW'(1);
                            r_txd <= w_shift_next[0];
                        end
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
`ifdef SERIAL_TX_PARITY_EN
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_timer <= '0;
                        r_state <= S_STOP;
                        r_txd   <= 1'b1;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (w_bit_end) begin
                        r_timer <= '0;
                        if (r_idx == S_LAST) begin
                            r_idx   <= '0;
                            r_state <= S_IDLE;
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_idx <= r_idx + BW'(1);
                        end
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_txd   <= 1'b1;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
